// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the programmable sequence detector
package seq_det_pkg;

  localparam logic MODE_OVERLAP = 1'b1;
  localparam logic MODE_NONOVL  = 1'b0;

  function automatic int fill_width(input int pat_len);
    return (pat_len < 2) ? 1 : $clog2(pat_len);
  endfunction

endpackage

// File: rtl/seq_shift_window.sv
// rtl/seq_shift_window.sv - history shift register of past valid bits with a saturating fill count
module seq_shift_window
  import seq_det_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         bit_in,
  input  logic         restart,
  output logic [W-1:0] window,
  output logic         full
);

  localparam int FW = fill_width(W + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(W);

  logic [W-1:0]  window_q, window_d;
  logic [FW-1:0] fill_q, fill_d;

  // restart only clears the fill; stale window bits are ignored until refilled
  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    if (shift_en) begin
      window_d = W'({window_q, bit_in});
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end
    if (restart) fill_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q <= '0;
      fill_q   <= '0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

  assign window = window_q;
  assign full   = (fill_q == FILL_MAX);

endmodule

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - runtime-programmable serial pattern detector with saturating match counter
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int          PAT_LEN = 4,
  parameter logic [31:0] PAT_RST = 32'b1101,
  parameter int          CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seq,
  input  logic               seq_vld,
  input  logic               overlap,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               pat_load,
  input  logic               cnt_clr,
  output logic               tick,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
    $error("seq_detect_prog: PAT_LEN must be within 2..32");
  end
  if ((PAT_RST >> PAT_LEN) != 32'd0) begin : g_bad_rst
    $error("seq_detect_prog: PAT_RST does not fit in PAT_LEN bits");
  end

  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic [PAT_LEN-2:0] window;
  logic [PAT_LEN-1:0] cand;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q;
  logic               full, hit, shift_en, restart, ovl_mode;

  assign ovl_mode = overlap ? MODE_OVERLAP : MODE_NONOVL;
  assign shift_en = seq_vld & ~pat_load;
  assign cand     = {window, seq};
  assign hit      = shift_en & full & (cand == pattern_q);
  assign restart  = pat_load | (hit & (ovl_mode == MODE_NONOVL));

  seq_shift_window #(.W(PAT_LEN - 1)) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .bit_in   (seq),
    .restart  (restart),
    .window   (window),
    .full     (full)
  );

  // clear has priority over a concurrent hit
  always_comb begin
    pattern_d = pat_load ? pat_in : pattern_q;
    cnt_d     = cnt_q;
    if (cnt_clr)              cnt_d = '0;
    else if (hit && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= PAT_LEN'(PAT_RST);
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      sat_q     <= &cnt_d;
    end
  end

  assign tick      = hit & ~rst;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule
